// File: rtl/cmd_in_queue_writer.sv
// rtl/cmd_in_queue_writer.sv - producer end of a circular command-in subqueue
//
// Accepts framed commands (header + N payload words) on a stream input.
// The block checks that all L = N+1 target slots are free, writes the
// payload words, and then publishes the header with bit 7 set. The consumer
// frees slots by clearing bit 7.
//
// Optional feature macro: CMD_IN_WRITER_STATS_EN (adds stat_cmds and
// stat_full_cycles counters).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_tdata/tvalid/   command stream; first word of a frame is the header,
//   in_tready/tlast    with [15:8] = payload word count N
//   queue_addr/en/we/  BRAM port (one 64-bit word per slot, 1-cycle read)
//   queue_din/dout
//   busy               high whenever a command is in progress
//   cmd_written        1-cycle pulse in the header publish cycle
//   err_len            1-cycle pulse: command longer than the queue, dropped
//   err_framing        1-cycle pulse: tlast not on the counted last word
//   stat_cmds          (stats build) published command count
//   stat_full_cycles   (stats build) check cycles that found a busy slot

module cmd_in_queue_writer #(
  parameter int QUEUE_DEPTH = 64,
  parameter int ADDR_W      = $clog2(QUEUE_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [63:0]       in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic              in_tlast,
  output logic [ADDR_W-1:0] queue_addr,
  output logic              queue_en,
  output logic [7:0]        queue_we,
  output logic [63:0]       queue_din,
  input  logic [63:0]       queue_dout,
  output logic              busy,
  output logic              cmd_written,
  output logic              err_len,
  output logic              err_framing
`ifdef CMD_IN_WRITER_STATS_EN
  ,
  output logic [31:0]       stat_cmds,
  output logic [31:0]       stat_full_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_PAYLOAD = 3'd2,
    S_HEADER  = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [31:0] DEPTH_U = 32'(QUEUE_DEPTH);

  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   wr_idx_q,  wr_idx_d;   // slot of the next header
  logic [63:0]         hdr_q,     hdr_d;      // header held until publish
  logic [7:0]          n_q,       n_d;        // payload word count
  logic [ADDR_W-1:0]   chk_idx_q, chk_idx_d;  // slot read in this CHECK cycle
  logic [8:0]          chk_cnt_q, chk_cnt_d;  // slots confirmed free so far
  logic                rd_pend_q, rd_pend_d;  // queue_dout holds a read to evaluate
  logic [7:0]          cnt_q,     cnt_d;      // payload/discard words consumed

  logic [8:0]  cmd_len;
  logic [7:0]  in_n;
  logic [8:0]  in_len;
  logic        in_too_long;
  logic        accept;
  logic        last_word;
  logic        full_hit;
  logic        unused_ok;

  assign cmd_len     = {1'b0, n_q} + 9'd1;
  assign in_n        = in_tdata[15:8];
  assign in_len      = {1'b0, in_n} + 9'd1;
  assign in_too_long = ({23'd0, in_len} > DEPTH_U);

  // A word is taken only out of reset; this also keeps every pulse low
  // while rstn is asserted.
  assign accept = in_tvalid & rstn;

  assign busy = (state_q != S_IDLE);

  // Only bit 7 of a slot matters for the occupancy check.
  assign unused_ok = ^{queue_dout[63:8], queue_dout[6:0], full_hit};

  // The BRAM port is driven combinationally from the state so that a
  // payload word lands in the same cycle as its handshake.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    hdr_d       = hdr_q;
    n_d         = n_q;
    chk_idx_d   = chk_idx_q;
    chk_cnt_d   = chk_cnt_q;
    rd_pend_d   = rd_pend_q;
    cnt_d       = cnt_q;
    in_tready   = 1'b0;
    queue_addr  = '0;
    queue_en    = 1'b0;
    queue_we    = 8'h00;
    queue_din   = 64'd0;
    cmd_written = 1'b0;
    err_len     = 1'b0;
    err_framing = 1'b0;
    last_word   = 1'b0;
    full_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_tready = rstn;
        if (accept) begin
          hdr_d       = in_tdata;
          n_d         = in_n;
          cnt_d       = 8'd0;
          err_framing = (in_tlast != (in_n == 8'd0));
          if (in_too_long) begin
            err_len = 1'b1;
            state_d = (in_n != 8'd0) ? S_DISCARD : S_IDLE;
          end else begin
            chk_idx_d = wr_idx_q;
            chk_cnt_d = 9'd0;
            rd_pend_d = 1'b0;
            state_d   = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        queue_en   = 1'b1;
        queue_addr = chk_idx_q;
        if (rd_pend_q) begin
          if (!queue_dout[7]) begin
            chk_cnt_d = chk_cnt_q + 9'd1;
            chk_idx_d = chk_idx_q + ADDR_W'(1);
            rd_pend_d = 1'b1;
            if (chk_cnt_q + 9'd1 == cmd_len) begin
              state_d = (n_q != 8'd0) ? S_PAYLOAD : S_HEADER;
            end
          end else begin
            // The slot just evaluated sits one behind the read now in
            // flight; drop that read and poll the busy slot again.
            full_hit  = 1'b1;
            chk_idx_d = chk_idx_q - ADDR_W'(1);
            rd_pend_d = 1'b0;
          end
        end else begin
          chk_idx_d = chk_idx_q + ADDR_W'(1);
          rd_pend_d = 1'b1;
        end
      end

      S_PAYLOAD: begin
        in_tready = rstn;
        if (accept) begin
          last_word   = (cnt_q == n_q - 8'd1);
          queue_en    = 1'b1;
          queue_we    = 8'hFF;
          queue_addr  = wr_idx_q + ADDR_W'(1) + ADDR_W'(cnt_q);
          queue_din   = in_tdata;
          err_framing = (in_tlast != last_word);
          cnt_d       = cnt_q + 8'd1;
          if (last_word) begin
            state_d = S_HEADER;
          end
        end
      end

      S_HEADER: begin
        queue_en    = 1'b1;
        queue_we    = 8'hFF;
        queue_addr  = wr_idx_q;
        queue_din   = {hdr_q[63:8], 1'b1, hdr_q[6:0]};
        wr_idx_d    = wr_idx_q + ADDR_W'(cmd_len);
        cmd_written = 1'b1;
        state_d     = S_IDLE;
      end

      S_DISCARD: begin
        in_tready = rstn;
        if (accept) begin
          last_word   = (cnt_q == n_q - 8'd1);
          err_framing = (in_tlast != last_word);
          cnt_d       = cnt_q + 8'd1;
          if (last_word) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wr_idx_q  <= '0;
      hdr_q     <= 64'd0;
      n_q       <= 8'd0;
      chk_idx_q <= '0;
      chk_cnt_q <= 9'd0;
      rd_pend_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      hdr_q     <= hdr_d;
      n_q       <= n_d;
      chk_idx_q <= chk_idx_d;
      chk_cnt_q <= chk_cnt_d;
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef CMD_IN_WRITER_STATS_EN
  logic [31:0] stat_cmds_q;
  logic [31:0] stat_full_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cmds_q <= 32'd0;
      stat_full_q <= 32'd0;
    end else begin
      if (cmd_written) begin
        stat_cmds_q <= stat_cmds_q + 32'd1;
      end
      if (full_hit) begin
        stat_full_q <= stat_full_q + 32'd1;
      end
    end
  end

  assign stat_cmds        = stat_cmds_q;
  assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: tb/tb_cmd_in_queue_writer.sv
// tb/tb_cmd_in_queue_writer.sv - self-checking bench for cmd_in_queue_writer

module tb_cmd_in_queue_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [5:0]  queue_addr;
  logic        queue_en;
  logic [7:0]  queue_we;
  logic [63:0] queue_din;
  logic [63:0] queue_dout = 64'd0;
  logic        busy;
  logic        cmd_written;
  logic        err_len;
  logic        err_framing;
`ifdef CMD_IN_WRITER_STATS_EN
  logic [31:0] stat_cmds;
  logic [31:0] stat_full_cycles;
`endif

  always #5 clk = ~clk;

  cmd_in_queue_writer #(.QUEUE_DEPTH(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_tdata    (in_tdata),
    .in_tvalid   (in_tvalid),
    .in_tready   (in_tready),
    .in_tlast    (in_tlast),
    .queue_addr  (queue_addr),
    .queue_en    (queue_en),
    .queue_we    (queue_we),
    .queue_din   (queue_din),
    .queue_dout  (queue_dout),
    .busy        (busy),
    .cmd_written (cmd_written),
    .err_len     (err_len),
    .err_framing (err_framing)
`ifdef CMD_IN_WRITER_STATS_EN
    ,
    .stat_cmds        (stat_cmds),
    .stat_full_cycles (stat_full_cycles)
`endif
  );

  // BRAM with 1-cycle read latency plus a consumer-side port.
  logic [63:0] mem [64];
  logic        cons_we   = 1'b0;
  logic [5:0]  cons_addr = 6'd0;
  logic [63:0] cons_data = 64'd0;
  logic        cons_clr  = 1'b0;
  logic        cons_zero = 1'b0;

  always @(posedge clk) begin
    if (cons_zero) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
    end else if (cons_clr) begin
      for (int i = 0; i < 64; i++) mem[i][7] <= 1'b0;
    end else if (cons_we) begin
      mem[cons_addr] <= cons_data;
    end
    if (queue_en) begin
      for (int b = 0; b < 8; b++)
        if (queue_we[b]) mem[queue_addr][b*8 +: 8] <= queue_din[b*8 +: 8];
      queue_dout <= mem[queue_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model of the command stream and the queue writes.
  int          m_wr, m_rem, m_i, m_n;
  logic        m_disc, m_pend;
  logic [63:0] m_hdr;
  int          cyc = 0, n_writes = 0, n_cmd = 0, n_errlen = 0, n_frm = 0;
  int          hdr_cyc = 0, cmd_cyc = 0, lastpay_cyc = 0;

  task automatic monitor();
    logic hs, exp_fr, exp_le, pay_wr;
    int   n;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rstn) begin
        m_wr = 0; m_rem = 0; m_i = 0; m_n = 0; m_disc = 1'b0; m_pend = 1'b0;
        continue;
      end
      hs = in_tvalid && in_tready;
      exp_fr = 1'b0; exp_le = 1'b0; pay_wr = 1'b0;
      if (hs) begin
        if (m_rem == 0) begin
          n       = int'(in_tdata[15:8]);
          exp_le  = (n + 1 > 64);
          exp_fr  = (in_tlast != (n == 0));
          m_rem   = n; m_i = 0; m_n = n; m_disc = exp_le; m_hdr = in_tdata;
          hdr_cyc = cyc;
          if (!exp_le && n == 0) m_pend = 1'b1;
        end else begin
          exp_fr = (in_tlast != (m_rem == 1));
          if (!m_disc) begin
            pay_wr = 1'b1;
            chk("payload_we",   64'(queue_we),   64'hFF);
            chk("payload_addr", 64'(queue_addr), 64'((m_wr + 1 + m_i) % 64));
            chk("payload_data", queue_din, in_tdata);
          end
          m_i++; m_rem--;
          if (m_rem == 0 && !m_disc) begin
            m_pend = 1'b1;
            lastpay_cyc = cyc;
          end
        end
      end
      chk("err_framing", 64'(err_framing), 64'(exp_fr));
      chk("err_len",     64'(err_len),     64'(exp_le));
      if (!pay_wr && (queue_we != 8'h00 || cmd_written)) begin
        chk("hdr_expected", 64'(m_pend), 64'd1);
        chk("hdr_we",       64'(queue_we), 64'hFF);
        chk("hdr_addr",     64'(queue_addr), 64'(m_wr));
        chk("hdr_data",     queue_din, m_hdr | 64'h80);
        chk("hdr_pulse",    64'(cmd_written), 64'd1);
        m_wr   = (m_wr + m_n + 1) % 64;
        m_pend = 1'b0;
      end
      if (queue_we != 8'h00) n_writes++;
      if (cmd_written) begin n_cmd++; cmd_cyc = cyc; end
      if (err_len) n_errlen++;
      if (err_framing) n_frm++;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int guard = 0;
    in_tdata = d; in_tlast = last; in_tvalid = 1'b1;
    while (!in_tready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) chk("send_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic wait_cmd(input int s, input int limit, input string nm);
    int k = 0;
    while (n_cmd == s && k < limit) begin @(negedge clk); #3; k++; end
    chk(nm, 64'(n_cmd - s), 64'd1);
    @(negedge clk);
  endtask

  task automatic consume();
    cons_clr = 1'b1;
    @(negedge clk);
    cons_clr = 1'b0;
  endtask

  task automatic cons_write(input logic [5:0] a, input logic [63:0] d);
    cons_addr = a; cons_data = d; cons_we = 1'b1;
    @(negedge clk);
    cons_we = 1'b0;
  endtask

  int s, s_we, s_el, s_fr;

  initial begin
    rstn = 1'b0; in_tvalid = 1'b0; in_tdata = 64'd0; in_tlast = 1'b0;
    cons_zero = 1'b1;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_tready", 64'(in_tready), 64'd0);
    chk("rst_en",     64'(queue_en), 64'd0);
    chk("rst_we",     64'(queue_we), 64'd0);
    chk("rst_cmd",    64'(cmd_written), 64'd0);
    @(negedge clk);
    cons_zero = 1'b0; rstn = 1'b1;
    #1;
    chk("idle_tready", 64'(in_tready), 64'd1);
    @(negedge clk);

    // Basic two-word command at wr_idx 0
    s = n_cmd;
    send(64'h0200, 1'b0); send(64'hA, 1'b0); send(64'hB, 1'b1);
    wait_cmd(s, 100, "t1_cmd");
    chk("t1_slot1", mem[1], 64'hA);
    chk("t1_slot2", mem[2], 64'hB);
    chk("t1_slot0", mem[0], 64'h280);
    chk("t1_latency", 64'(cmd_cyc - hdr_cyc), 64'd7);
    consume();

    // Long command moves wr_idx from 3 to 62
    s = n_cmd;
    send(64'h3A00, 1'b0);
    for (int i = 0; i < 58; i++) send(64'h1000 + 64'(i), i == 57);
    wait_cmd(s, 300, "fill_cmd");
    chk("fill_hdr",   mem[3],  64'h3A80);
    chk("fill_first", mem[4],  64'h1000);
    chk("fill_last",  mem[61], 64'h1039);
    consume();

    // Wrap-around at wr_idx 62
    s = n_cmd;
    send(64'hDEAD_0000_0000_0300, 1'b0);
    send(64'h111, 1'b0); send(64'h222, 1'b0); send(64'h333, 1'b1);
    wait_cmd(s, 100, "t2_cmd");
    chk("t2_slot63", mem[63], 64'h111);
    chk("t2_slot0",  mem[0],  64'h222);
    chk("t2_slot1",  mem[1],  64'h333);
    chk("t2_slot62", mem[62], 64'hDEAD_0000_0000_0380);
    consume();

    // Oversized command is dropped
    s_we = n_writes; s_el = n_errlen; s_fr = n_frm;
    send(64'h4000, 1'b0);
    for (int i = 0; i < 64; i++) send(64'(i), i == 63);
    @(negedge clk);
    chk("t4_busy",   64'(busy), 64'd0);
    chk("t4_writes", 64'(n_writes - s_we), 64'd0);
    chk("t4_errlen", 64'(n_errlen - s_el), 64'd1);
    chk("t4_frm",    64'(n_frm - s_fr), 64'd0);

    // tlast on the header of an N=1 command, wr_idx still 2
    s = n_cmd; s_fr = n_frm;
    send(64'h0100, 1'b1); send(64'h55, 1'b1);
    wait_cmd(s, 100, "t5_cmd");
    chk("t5_frm",   64'(n_frm - s_fr), 64'd1);
    chk("t5_slot3", mem[3], 64'h55);
    chk("t5_slot2", mem[2], 64'h180);
    consume();

    // Busy slot stalls the command at wr_idx 4 until the consumer frees it
    cons_write(6'd5, 64'h80);
    s = n_cmd;
    send(64'h0200, 1'b0);
    fork
      begin
        send(64'hC, 1'b0); send(64'hD, 1'b1);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk); #3;
          chk("t3_stall_tready", 64'(in_tready), 64'd0);
          chk("t3_stall_we", 64'(queue_we), 64'd0);
        end
        @(negedge clk);
        cons_write(6'd5, 64'h0);
      end
    join
    wait_cmd(s, 50, "t3_cmd");
    chk("t3_slot5", mem[5], 64'hC);
    chk("t3_slot6", mem[6], 64'hD);
    chk("t3_slot4", mem[4], 64'h280);
    chk("t3_hdr_after_payload", 64'(cmd_cyc - lastpay_cyc), 64'd1);
`ifdef CMD_IN_WRITER_STATS_EN
    chk("t3_stat_full", 64'(stat_full_cycles != 32'd0), 64'd1);
`endif

    // Reset in the middle of a payload at wr_idx 7
    send(64'h0300, 1'b0); send(64'h77, 1'b0);
    #1;
    chk("t6_busy_before", 64'(busy), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_busy",   64'(busy), 64'd0);
    chk("t6_tready", 64'(in_tready), 64'd0);
    chk("t6_en",     64'(queue_en), 64'd0);
    chk("t6_slot8",  mem[8], 64'h77);
`ifdef CMD_IN_WRITER_STATS_EN
    chk("t6_stat_rst", 64'(stat_cmds), 64'd0);
`endif
    @(negedge clk);
    cons_zero = 1'b1;
    @(negedge clk);
    cons_zero = 1'b0; rstn = 1'b1;
    @(negedge clk);
    s = n_cmd;
    send(64'h0000, 1'b1);
    wait_cmd(s, 50, "t6_cmd");
    chk("t6_slot0", mem[0], 64'h80);
`ifdef CMD_IN_WRITER_STATS_EN
    chk("t6_stat_cmds", 64'(stat_cmds), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
